// File: rtl/klp32_branch_pkg.sv
//------------------------------------------------------------------------------
// klp32_branch_pkg : shared constants and types for branch resolution
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package klp32_branch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

endpackage

`default_nettype wire

// File: rtl/branch_target.sv
//------------------------------------------------------------------------------
// branch_target : target adder, JALR LSB clear and 4-byte alignment check
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_target
  import klp32_branch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            is_jalr_i,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;

  assign w_base = is_jalr_i ? rs1_i : pc_i;
  assign w_sum  = w_base + imm_i;

  assign target_o     = is_jalr_i ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
  // Bit 0 never matters for alignment: JALR clears it, RV32I offsets are even.
  assign misaligned_o = w_sum[1];

endmodule

`default_nettype wire

// File: rtl/branch_resolve_pc.sv
//------------------------------------------------------------------------------
// branch_resolve_pc : execute-stage branch decision, fetch PC and flush control
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_resolve_pc
  import klp32_branch_pkg::*;
#(
  parameter int          XLEN         = XLEN_DEFAULT,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            valid,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] imm,
  input  logic            BrEq,
  input  logic            BrLT,
  output logic            BrUn,
  output logic [XLEN-1:0] pc,
  output logic            taken,
  output logic            flush,
  output logic            misaligned,
  output logic            illegal_br
);

  localparam int c_cnt_w = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(FLUSH_CYCLES - 1);

  br_state_e           state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                taken_q, taken_d;
  logic                flush_q, flush_d;
  logic                mis_q, mis_d;
  logic                ill_q, ill_d;

  logic                w_sel_jalr, w_sel_jal, w_sel_br;
  logic                w_cond, w_f3_illegal;
  logic                w_take, w_illegal;
  logic [XLEN-1:0]     w_target;
  logic                w_target_mis;

  assign BrUn = funct3[1];

  // Priority JALR > JAL > branch when the one-hot contract is broken.
  assign w_sel_jalr = is_jalr;
  assign w_sel_jal  = is_jal & ~is_jalr;
  assign w_sel_br   = is_branch & ~is_jal & ~is_jalr;

  always_comb begin
    w_cond       = 1'b0;
    w_f3_illegal = 1'b0;
    case (funct3)
      F3_BEQ:          w_cond = BrEq;
      F3_BNE:          w_cond = ~BrEq;
      F3_BLT, F3_BLTU: w_cond = BrLT;
      F3_BGE, F3_BGEU: w_cond = ~BrLT;
      default:         w_f3_illegal = 1'b1;
    endcase
  end

  assign w_take    = valid & (w_sel_jalr | w_sel_jal | (w_sel_br & w_cond));
  assign w_illegal = valid & w_sel_br & w_f3_illegal;

  branch_target #(
    .XLEN (XLEN)
  ) u_target (
    .pc_i         (ex_pc),
    .rs1_i        (rs1_data),
    .imm_i        (imm),
    .is_jalr_i    (w_sel_jalr),
    .target_o     (w_target),
    .misaligned_o (w_target_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= XLEN'(RESET_PC);
      taken_q <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
    end
  end

  // A stall freezes every register, including pending pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    taken_d = taken_q;
    flush_d = flush_q;
    mis_d   = mis_q;
    ill_d   = ill_q;
    if (!stall) begin
      case (state_q)
        RUN: begin
          taken_d = 1'b0;
          flush_d = 1'b0;
          mis_d   = w_take & w_target_mis;
          ill_d   = w_illegal;
          if (w_take && !w_target_mis) begin
            pc_d    = w_target;
            taken_d = 1'b1;
            flush_d = 1'b1;
            cnt_d   = c_cnt_init;
            state_d = FLUSH;
          end else begin
            pc_d = pc_q + XLEN'(4);
          end
        end
        FLUSH: begin
          taken_d = 1'b0;
          mis_d   = 1'b0;
          ill_d   = 1'b0;
          pc_d    = pc_q + XLEN'(4);
          if (cnt_q == '0) begin
            flush_d = 1'b0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - c_cnt_w'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign pc         = pc_q;
  assign taken      = taken_q;
  assign flush      = flush_q;
  assign misaligned = mis_q;
  assign illegal_br = ill_q;

endmodule

`default_nettype wire

// File: doc/branch_resolve_pc.md
# branch_resolve_pc

Execute-stage branch resolution and program-counter register for the KLP32 RV32I core. It sits directly downstream of `branch_comp`. It drives `BrUn` into the comparator and consumes the comparator's `BrEq`/`BrLT` to decide taken/not-taken for conditional branches, JAL and JALR. It computes and checks the target, then owns the architectural fetch PC, redirecting it and generating a counted pipeline flush.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `FLUSH_CYCLES`, 2, number of younger-instruction slots squashed after a redirect (≥1).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 1: hazard stall; freezes PC and flush counter.
- `valid` input 1: execute-stage instruction is valid.
- `is_branch` input 1: conditional branch.
- `is_jal` input 1: JAL.
- `is_jalr` input 1: JALR.
- `funct3` input 3: branch condition field.
- `ex_pc` input XLEN: PC of the execute-stage instruction.
- `rs1_data` input XLEN: JALR base.
- `imm` input XLEN: sign-extended immediate.
- `BrEq` input 1: from `branch_comp`.
- `BrLT` input 1: from `branch_comp`.
- `BrUn` output 1: to `branch_comp`; combinational, equals `funct3[1]`.
- `pc` output XLEN: fetch PC (registered).
- `taken` output 1: registered pulse; the previous-cycle instruction redirected.
- `flush` output 1: registered; squash fetch/decode this cycle.
- `misaligned` output 1: registered pulse; taken target not 4-byte aligned.
- `illegal_br` output 1: registered pulse; `is_branch` with `funct3` 010/011.

## Operation
- Conditions: `funct3` 000 BEQ=`BrEq`; 001 BNE=`!BrEq`; 100 BLT / 110 BLTU=`BrLT`; 101 BGE / 111 BGEU=`!BrLT`; 010/011 are not taken and set `illegal_br`.
- `take` = `valid & ((is_branch & cond) | is_jal | is_jalr)`. The one-hot `is_*` inputs are mutually exclusive by contract. If several are set, priority is JALR > JAL > branch.
- Target: branch/JAL = `ex_pc + imm`; JALR = `(rs1_data + imm) & ~1`. Both are modulo 2^XLEN, so wrap-around is silent.
- Alignment: if `take` and `target[1]`=1, do not redirect. Pulse `misaligned` and continue sequentially.
- FSM states:
  - RUN:
    - `stall`: hold everything.
    - Else `take` and aligned: `pc`←target, `taken`←1, `flush`←1, counter←`FLUSH_CYCLES-1`, go to FLUSH.
    - Else: `pc`←`pc+4`.
  - FLUSH:
    - The `valid`/`is_*` inputs are ignored (squashed) and no pulses are generated.
    - `stall`: hold `pc` and counter; `flush` stays 1.
    - Else: `pc`←`pc+4`.
      - Counter=0: `flush`←0, go to RUN.
      - Counter≠0: decrement counter.
- A taken instruction arriving with `stall`=1 is not resolved. It is re-evaluated when `stall` drops.

## Timing
- Reset values: `pc`=`RESET_PC`, `taken`=0, `flush`=0, `misaligned`=0, `illegal_br`=0, state RUN, counter 0.
- Reset wins over every other input. Reset during FLUSH returns to RUN with `flush`=0 on the next edge.
- Decision latency is 1 cycle. In cycle N the inputs are sampled. At edge N+1, `pc`=target and `taken`=1. `flush` is high for exactly `FLUSH_CYCLES` unstalled cycles starting at N+1.
- Each pulse output (`taken`, `misaligned`, `illegal_br`) is high for one cycle, or held while `stall` is asserted in that cycle.
- `BrUn` is purely combinational with zero latency. The comparator → condition → target → `pc` path is one cycle.

## Structure
- Package `klp32_branch_pkg`:
  - `F3_BEQ`..`F3_BGEU` localparams.
  - `br_state_e` enum {RUN, FLUSH}.
  - `XLEN` default.
- Sub-module `branch_target`: combinational target adder, JALR LSB mask, and alignment check.
- The top level holds the condition decode, FSM, counter and PC register.

## Test plan
- Reset, then 3 unstalled cycles: `pc` = 0, 4, 8, 12. `flush`=0, `taken`=0.
- BEQ with `BrEq`=1, `ex_pc`=0x100, `imm`=0x40: next edge `pc`=0x140, `taken`=1. `flush` high for 2 cycles; `pc` = 0x144, then 0x148 after.
- BLTU (`funct3`=110): `BrUn`=1 immediately. `BrLT`=0: no redirect, `pc`+=4. BGE with `BrLT`=1: not taken.
- JALR with `rs1_data`=0x2001, `imm`=0x3: target 0x2004, taken. With `imm`=0x1: target 0x2002, so `misaligned`=1 and `pc` sequential.
- JAL with `ex_pc`=0xFFFF_FFF0, `imm`=0x20: `pc`=0x0000_0010 (wrap).
- A taken branch with `stall` held for 2 cycles resolves on the first unstalled cycle. `rst` asserted on the first flush cycle: next `pc`=`RESET_PC`, `flush`=0. A branch presented during FLUSH is ignored.
